linear_network_gather_pipe: RTL and testbench
=============================================

// Module: linear_network_gather_pipe
// PURPOSE
// - Return-path counterpart of the linear multicast distribution chain: collects one beat from each
//   selected node (mask i_cmd) over a linear chain of registered 2:1 merge stages to one output port.
// - Sits between the PE/node array and the global buffer write port; beats carry source node id.
// PARAMETERS
// - DATA_WIDTH  32  payload width per beat
// - NUM_NODE    4   node count (>=2); stage k injects node k; stage NUM_NODE-1 drives output
// - ID_WIDTH    $clog2(NUM_NODE)  source id width (localparam, not overridable)
// PORTS
// - clk           in   1                      clock, all state on rising edge
// - rst           in   1                      synchronous active-high reset
// - i_en          in   1                      global enable; 0 freezes all state
// - i_start       in   1                      1-cycle pulse, latch i_cmd and begin transaction
// - i_cmd         in   NUM_NODE               participation mask, bit k = node k
// - i_valid       in   NUM_NODE               per-node beat valid
// - i_data_bus    in   DATA_WIDTH*NUM_NODE    node k payload at [k*DATA_WIDTH+:DATA_WIDTH]
// - o_ready       out  NUM_NODE               per-node accept; handshake = i_valid[k]&o_ready[k]
// - o_valid       out  1                      output beat valid
// - o_data_bus    out  DATA_WIDTH             output payload
// - o_src         out  ID_WIDTH               node id of output beat
// - i_ready       in   1                      downstream accept; handshake = o_valid&i_ready
// - o_busy        out  1                      transaction in progress
// - o_done        out  1                      1-cycle pulse, all masked beats delivered
// BEHAVIOUR
// - Reset: state IDLE, all stage valids 0, mask/taken/count 0; o_valid=o_busy=o_done=0, o_ready=0.
// - FSM IDLE->COLLECT on i_start&i_en (latch mask=i_cmd, taken=0, count=0); COLLECT->DONE when
//   count==popcount(mask); DONE->IDLE next cycle, o_done=1 in DONE only. i_start outside IDLE ignored.
// - i_start with i_cmd==0: COLLECT->DONE on next cycle, o_done one cycle after that, no output beats.
// - Stage k register {valid,data,src}; can_take = !valid | down_take (last stage: i_ready&i_en).
// - Stage k selects upstream (stage k-1 valid) or local node k; upstream has strict priority
//   (see CONFIGURATION). Stage 0 has local only.
// - o_ready[k] = i_en & COLLECT & mask[k] & !taken[k] & can_take[k] & !(upstream selected);
//   on handshake set taken[k]; node sends exactly one beat per transaction; unmasked i_valid ignored.
// - Latency, no stalls: node k handshake in cycle t -> o_valid in cycle t+(NUM_NODE-k).
// - Throughput: one beat/cycle at output under continuous i_ready; backpressure ripples
//   combinationally (can_take chain), no beat dropped or duplicated.
// - o_valid = last stage valid & i_en; count increments on output handshake (width ID_WIDTH+1).
// - i_en=0: no handshakes, no register/FSM updates, o_ready=0, o_valid=0; resume exact state.
// - Beat order at output: any; o_src identifies source. o_data_bus/o_src hold when o_valid=0.
// - rst mid-transaction: all in-flight beats discarded, return to IDLE, no o_done.
// CONFIGURATION
// - LINEAR_GATHER_RR_EN defined: each stage keeps 1-bit priority toggle; when upstream and local
//   both pending, winner alternates and toggle flips on each contested grant (reset: upstream first).
// - Undefined: upstream strict priority; node k may wait until upstream traffic drains.
// STRUCTURE
// - Package linear_network_pkg: gather FSM state enum (IDLE/COLLECT/DONE), id width function.
// - Sub-module linear_gather_stage: one merge register + select/priority + can_take; instantiated
//   NUM_NODE times in generate loop, stage 0 with upstream valid tied 0.
// - Top holds FSM, mask/taken registers, output beat counter, popcount.
// TESTING
// - NUM_NODE=4, i_cmd=4'b1111, all i_valid=1 at once, i_ready=1 -> 4 output beats, o_src set
//   {0,1,2,3} each once, o_done 1 cycle after last beat.
// - i_cmd=4'b0101, all nodes valid -> only nodes 0,2 see o_ready; 2 beats; o_ready[1]/[3] never high.
// - Only node 3 valid, i_ready=1 -> o_valid exactly 1 cycle after handshake; node 0 -> 4 cycles.
// - i_ready=0 for 10 cycles mid-transaction -> chain fills (4 beats held), o_ready all 0; release
//   -> all 4 beats delivered in 4 consecutive cycles, data unchanged.
// - i_en=0 for 3 cycles mid-flight -> o_valid=0, state frozen; resume identical to un-paused run
//   shifted by 3 cycles. rst pulse mid-flight -> o_valid=0, o_busy=0, no o_done.
// - i_cmd=0 start -> o_done pulse 2 cycles later, no beats; RR_EN build: node 1 starved-upstream
//   case gets a grant within 2 contested cycles.

Source files
------------

// File: rtl/linear_network_pkg.sv
// Shared types and helpers for the linear gather network.
package linear_network_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } gather_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/linear_network_gather_pipe_stage.sv
// One registered 2:1 merge stage of the gather chain.
// LINEAR_GATHER_RR_EN selects round-robin arbitration instead of upstream priority.
module linear_gather_stage
    import linear_network_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int NODE_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_up_valid,
    input  logic [DATA_WIDTH-1:0] i_up_data,
    input  logic [ID_WIDTH-1:0]   i_up_src,
    input  logic                  i_loc_elig,
    input  logic                  i_loc_valid,
    input  logic [DATA_WIDTH-1:0] i_loc_data,
    input  logic                  i_down_take,
    output logic                  o_up_take,
    output logic                  o_loc_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ID_WIDTH-1:0]   o_src
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]   r_src;
    logic                  w_can_take;
    logic                  w_loc_pend;
    logic                  w_up_sel;
    logic                  w_loc_hs;

    assign w_can_take = !r_valid | i_down_take;
    assign w_loc_pend = i_loc_elig & i_loc_valid;

`ifdef LINEAR_GATHER_RR_EN
    // r_prio=0: upstream wins the next contested slot
    logic r_prio;

    assign w_up_sel = i_up_valid & (!w_loc_pend | !r_prio);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (i_en & w_can_take & i_up_valid & w_loc_pend) begin
            r_prio <= !r_prio;
        end
    end
`else
    assign w_up_sel = i_up_valid;
`endif

    assign o_loc_ready = i_en & i_loc_elig & w_can_take & !w_up_sel;
    assign o_up_take   = i_en & w_can_take & w_up_sel;
    assign w_loc_hs    = o_loc_ready & i_loc_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (i_en & w_can_take) begin
            r_valid <= o_up_take | w_loc_hs;
            if (o_up_take) begin
                r_data <= i_up_data;
                r_src  <= i_up_src;
            end else if (w_loc_hs) begin
                r_data <= i_loc_data;
                r_src  <= ID_WIDTH'(NODE_ID);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_src   = r_src;

endmodule

// File: rtl/linear_network_gather_pipe.sv
// Gather one beat per masked node over a linear chain of merge stages.
// Optional macro LINEAR_GATHER_RR_EN: round-robin merge arbitration.
module linear_network_gather_pipe
    import linear_network_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_NODE   = 4,
    localparam int ID_WIDTH   = id_width(NUM_NODE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic                           i_start,
    input  logic [NUM_NODE-1:0]            i_cmd,
    input  logic [NUM_NODE-1:0]            i_valid,
    input  logic [DATA_WIDTH*NUM_NODE-1:0] i_data_bus,
    output logic [NUM_NODE-1:0]            o_ready,
    output logic                           o_valid,
    output logic [DATA_WIDTH-1:0]          o_data_bus,
    output logic [ID_WIDTH-1:0]            o_src,
    input  logic                           i_ready,
    output logic                           o_busy,
    output logic                           o_done
);

    function automatic logic [ID_WIDTH:0] popcount(input logic [NUM_NODE-1:0] v);
        logic [ID_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < NUM_NODE; i++) c = c + {{ID_WIDTH{1'b0}}, v[i]};
        return c;
    endfunction

    gather_state_t       r_state;
    gather_state_t       w_state_nxt;
    logic [NUM_NODE-1:0] r_mask;
    logic [NUM_NODE-1:0] r_taken;
    logic [ID_WIDTH:0]   r_count;
    logic [ID_WIDTH:0]   w_count_nxt;
    logic                w_out_hs;
    logic [NUM_NODE-1:0] w_loc_elig;
    logic [NUM_NODE:0]   w_take;
    logic                w_unused;

    logic [NUM_NODE-1:0]   w_stg_valid;
    logic [DATA_WIDTH-1:0] w_stg_data [NUM_NODE];
    logic [ID_WIDTH-1:0]   w_stg_src  [NUM_NODE];

    assign w_out_hs    = o_valid & i_ready;
    assign w_count_nxt = r_count + {{ID_WIDTH{1'b0}}, w_out_hs};
    assign w_loc_elig  = (r_state == S_COLLECT) ? (r_mask & ~r_taken) : '0;
    assign w_take[NUM_NODE] = i_ready & i_en;
    assign w_unused    = w_take[0];

    for (genvar k = 0; k < NUM_NODE; k++) begin : g_stage
        logic                  w_up_valid;
        logic [DATA_WIDTH-1:0] w_up_data;
        logic [ID_WIDTH-1:0]   w_up_src;

        if (k == 0) begin : g_head
            assign w_up_valid = 1'b0;
            assign w_up_data  = '0;
            assign w_up_src   = '0;
        end else begin : g_link
            assign w_up_valid = w_stg_valid[k-1];
            assign w_up_data  = w_stg_data[k-1];
            assign w_up_src   = w_stg_src[k-1];
        end

        linear_gather_stage #(
            .DATA_WIDTH(DATA_WIDTH),
            .ID_WIDTH  (ID_WIDTH),
            .NODE_ID   (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .i_en       (i_en),
            .i_up_valid (w_up_valid),
            .i_up_data  (w_up_data),
            .i_up_src   (w_up_src),
            .i_loc_elig (w_loc_elig[k]),
            .i_loc_valid(i_valid[k]),
            .i_loc_data (i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_down_take(w_take[k+1]),
            .o_up_take  (w_take[k]),
            .o_loc_ready(o_ready[k]),
            .o_valid    (w_stg_valid[k]),
            .o_data     (w_stg_data[k]),
            .o_src      (w_stg_src[k])
        );
    end

    // next-count compare lets DONE follow the final output beat directly
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_count_nxt == popcount(r_mask)) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (i_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= '0;
            r_taken <= '0;
            r_count <= '0;
        end else if (i_en) begin
            if (r_state == S_IDLE && i_start) begin
                r_mask  <= i_cmd;
                r_taken <= '0;
                r_count <= '0;
            end else begin
                r_taken <= r_taken | (i_valid & o_ready);
                r_count <= w_count_nxt;
            end
        end
    end

    assign o_valid    = w_stg_valid[NUM_NODE-1] & i_en;
    assign o_data_bus = w_stg_data[NUM_NODE-1];
    assign o_src      = w_stg_src[NUM_NODE-1];
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_linear_network_gather_pipe.sv
// Self-checking bench: scoreboard model plus directed and random transactions.
module tb_linear_network_gather_pipe;

    localparam int DW = 32;
    localparam int NN = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_en;
    logic             i_start;
    logic [NN-1:0]    i_cmd;
    logic [NN-1:0]    i_valid;
    logic [DW*NN-1:0] i_data_bus;
    logic [NN-1:0]    o_ready;
    logic             o_valid;
    logic [DW-1:0]    o_data_bus;
    logic [IW-1:0]    o_src;
    logic             i_ready;
    logic             o_busy;
    logic             o_done;

    linear_network_gather_pipe #(.DATA_WIDTH(DW), .NUM_NODE(NN)) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_start(i_start), .i_cmd(i_cmd),
        .i_valid(i_valid), .i_data_bus(i_data_bus), .o_ready(o_ready),
        .o_valid(o_valid), .o_data_bus(o_data_bus), .o_src(o_src),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard model: which nodes have handed over a beat, which beats are in flight
    bit            m_active = 0;
    bit            m_nostall = 0;
    bit            prev_done = 0;
    logic [NN-1:0] m_mask = '0;
    logic [NN-1:0] m_taken = '0;
    logic [NN-1:0] m_inq = '0;
    logic [NN-1:0] ever_ready = '0;
    logic [DW-1:0] m_data [NN];
    int            m_hs_cyc [NN];
    int            m_del = 0;
    int            m_last_out = 0;
    int            m_start_cyc = 0;
    int            m_dones = 0;
    int            q_src [$];
    int            q_cyc [$];

    always @(negedge clk) begin
        if (rst) begin
            m_active  = 0;
            m_inq     = '0;
            prev_done = 0;
        end else begin
            ever_ready |= o_ready;
            if (!i_en) chk("valid_gated_by_en", o_valid, 0);
            for (int k = 0; k < NN; k++)
                if (o_ready[k])
                    chk("ready_legal", m_active && m_mask[k] && !m_taken[k] && i_en, 1);
            if (o_valid && i_ready) begin
                chk("out_pending", m_inq[o_src], 1);
                chk("out_data", o_data_bus, m_data[o_src]);
                if (m_nostall) chk("latency", cyc - m_hs_cyc[o_src], NN - int'(o_src));
                m_inq[o_src] = 1'b0;
                m_del++;
                m_last_out = cyc;
                q_src.push_back(int'(o_src));
                q_cyc.push_back(cyc - m_start_cyc);
            end
            for (int k = 0; k < NN; k++)
                if (i_valid[k] && o_ready[k]) begin
                    m_taken[k]  = 1'b1;
                    m_inq[k]    = 1'b1;
                    m_data[k]   = i_data_bus[k*DW +: DW];
                    m_hs_cyc[k] = cyc;
                end
            if (o_done && !prev_done) begin
                chk("done_expected", m_active, 1);
                chk("done_all_delivered", m_del, $countones(m_mask));
                chk("done_nothing_inflight", m_inq, 0);
                if (m_mask != 0) chk("done_timing", cyc, m_last_out + 1);
                m_active = 0;
                m_dones++;
            end
            prev_done = o_done;
            if (i_start && i_en && !m_active) begin
                m_active    = 1;
                m_mask      = i_cmd;
                m_taken     = '0;
                m_inq       = '0;
                m_del       = 0;
                m_start_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [NN-1:0] mask);
        q_src.delete();
        q_cyc.delete();
        ever_ready = '0;
        i_cmd   = mask;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic finish_txn(input string name);
        int n = 0;
        while (m_active && n < 200) begin
            tick();
            i_valid = i_valid & ~m_taken;
            n++;
        end
        chk({name, "_completes"}, m_active, 0);
        i_en = 1'b1;
        i_valid = '0;
        tick();
        tick();
    endtask

    function automatic logic [NN-1:0] src_set();
        logic [NN-1:0] s = '0;
        foreach (q_src[i]) s[q_src[i]] = 1'b1;
        return s;
    endfunction

    task automatic rand_txn();
        logic [NN-1:0] mask;
        int d [NN];
        int t = 0;
        mask = NN'($urandom);
        for (int k = 0; k < NN; k++) d[k] = $urandom_range(0, 5);
        i_data_bus = {$urandom, $urandom, $urandom, $urandom};
        i_valid = '0;
        i_en = 1'b1;
        i_ready = 1'b1;
        start_txn(mask);
        while (m_active && t < 300) begin
            i_en    = ($urandom_range(0, 7) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NN; k++) begin
                if (mask[k]) begin
                    i_valid[k] = !m_taken[k] && (t >= d[k]);
                end else begin
                    i_valid[k] = 1'($urandom_range(0, 1));
                    i_data_bus[k*DW +: DW] = $urandom;
                end
            end
            tick();
            t++;
        end
        chk("rand_completes", m_active, 0);
        chk("rand_beat_count", q_src.size(), $countones(mask));
        chk("rand_src_set", src_set(), mask);
        i_en = 1'b1;
        i_valid = '0;
        i_ready = 1'b1;
        tick();
        tick();
    endtask

    int a_src [NN];
    int a_cyc [NN];
    int d0;

    initial begin
        rst = 1'b1; i_en = 1'b1; i_start = 1'b0; i_cmd = '0;
        i_valid = '1; i_data_bus = '0; i_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_busy", o_busy, 0);
        chk("reset_o_done", o_done, 0);
        chk("reset_o_ready", o_ready, 0);

        // all nodes, no stalls: hs in start+1, outputs start+2..start+5
        i_data_bus = {$urandom, $urandom, $urandom, $urandom};
        m_nostall = 1;
        start_txn(4'b1111);
        finish_txn("all4");
        m_nostall = 0;
        chk("all4_count", q_src.size(), 4);
        chk("all4_srcset", src_set(), 4'b1111);
        for (int i = 0; i < NN && i < q_cyc.size(); i++) begin
            chk("all4_cycle", q_cyc[i], 2 + i);
            a_src[i] = q_src[i];
            a_cyc[i] = q_cyc[i];
        end

        i_valid = '1;
        start_txn(4'b0101);
        finish_txn("mask0101");
        chk("mask0101_count", q_src.size(), 2);
        chk("mask0101_srcset", src_set(), 4'b0101);
        chk("mask0101_ready_seen", ever_ready, 4'b0101);

        i_valid = 4'b1000;
        m_nostall = 1;
        start_txn(4'b1000);
        finish_txn("node3");
        if (q_cyc.size() > 0) chk("node3_latency", q_cyc[0], 2);
        i_valid = 4'b0001;
        start_txn(4'b0001);
        finish_txn("node0");
        m_nostall = 0;
        if (q_cyc.size() > 0) chk("node0_latency", q_cyc[0], 5);

        i_valid = '1;
        i_ready = 1'b0;
        i_data_bus = {$urandom, $urandom, $urandom, $urandom};
        start_txn(4'b1111);
        repeat (10) begin
            tick();
            i_valid = i_valid & ~m_taken;
        end
        chk("stall_ready_zero", o_ready, 0);
        chk("stall_o_valid", o_valid, 1);
        chk("stall_busy", o_busy, 1);
        chk("stall_no_output", q_src.size(), 0);
        i_ready = 1'b1;
        finish_txn("stall");
        chk("stall_count", q_src.size(), 4);
        for (int i = 1; i < q_cyc.size(); i++)
            chk("stall_consecutive", q_cyc[i], q_cyc[0] + i);

        i_valid = '1;
        start_txn(4'b1111);
        tick();
        i_en = 1'b0;
        repeat (3) tick();
        i_en = 1'b1;
        finish_txn("pause");
        chk("pause_count", q_src.size(), 4);
        for (int i = 0; i < NN && i < q_cyc.size(); i++) begin
            chk("pause_src", q_src[i], a_src[i]);
            chk("pause_shift", q_cyc[i], a_cyc[i] + 3);
        end

        d0 = m_dones;
        i_valid = '1;
        i_ready = 1'b0;
        start_txn(4'b1111);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_o_valid", o_valid, 0);
        chk("rst_mid_o_busy", o_busy, 0);
        chk("rst_mid_o_ready", o_ready, 0);
        i_valid = '0;
        i_ready = 1'b1;
        repeat (8) tick();
        chk("rst_mid_no_done", m_dones, d0);

        start_txn(4'b0000);
        chk("cmd0_done_early", o_done, 0);
        chk("cmd0_busy", o_busy, 1);
        tick();
        chk("cmd0_done_pulse", o_done, 1);
        tick();
        tick();
        chk("cmd0_no_beats", q_src.size(), 0);
        chk("cmd0_idle", o_busy, 0);

        repeat (40) rand_txn();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
